// File: rtl/prefetcher_op_sched.sv
// ---------------------------------------------------------------------------
// prefetcher_op_sched
//
// Purpose:
//   Per-cycle opcode scheduler in front of the prefetcher data queue. The
//   queue accepts exactly one opcode per clock. Each cycle this block picks
//   one of four requesters and turns its valid/ready handshake into a single
//   queue opcode:
//     3 = slave read data, 2 = master AR, 4 = master R read-out (promise),
//     1 = prefetch generator, 0 = NOP.
//   Slave data has fixed top priority, with a starvation guard. The other
//   three share the remaining slots round robin. An IDLE/RUN/DRAIN/ERROR
//   state machine gates which requesters may be served.
//
// Ports:
//   clk, resetN                  clock (posedge) / async active-low reset
//   crs_enable, crs_errClear     run enable / error clear pulse
//   s_r_valid / s_r_ready        slave read data handshake
//   m_ar_valid / m_ar_ready      master read address handshake
//   m_ar_addr                    master block-aligned address
//   m_r_valid / m_r_ready        data beat towards the master
//   pf_valid / pf_ready          prefetch request handshake
//   pf_addr                      prefetch block-aligned address
//   q_pr_r_valid                 queue has a deliverable beat
//   q_almostFull                 queue status
//   q_hasOutstanding             queue status
//   q_errorCode                  queue error for the previous opcode
//   q_reqOpcode, q_reqAddr       opcode and address sent to the queue
//   state                        0 IDLE, 1 RUN, 2 DRAIN, 3 ERROR
//   errLatched                   first nonzero error since the last clear
// ---------------------------------------------------------------------------
module prefetcher_op_sched #(
  parameter int LOG_QUEUE_SIZE = 8,
  parameter int ADDR_BITS      = 64,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 crs_enable,
  input  logic                 crs_errClear,
  input  logic                 s_r_valid,
  output logic                 s_r_ready,
  input  logic                 m_ar_valid,
  output logic                 m_ar_ready,
  input  logic [ADDR_BITS-1:0] m_ar_addr,
  output logic                 m_r_valid,
  input  logic                 m_r_ready,
  input  logic                 pf_valid,
  output logic                 pf_ready,
  input  logic [ADDR_BITS-1:0] pf_addr,
  input  logic                 q_pr_r_valid,
  input  logic                 q_almostFull,
  input  logic                 q_hasOutstanding,
  input  logic [2:0]           q_errorCode,
  output logic [2:0]           q_reqOpcode,
  output logic [ADDR_BITS-1:0] q_reqAddr,
  output logic [1:0]           state,
  output logic [2:0]           errLatched
);

  // Named empty block: an out-of-range parameter set shows up in the
  // elaborated hierarchy as g_illegalParams.
  if (LOG_QUEUE_SIZE < 1 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_illegalParams
  end

  localparam logic [7:0] LP_LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t     r_state, w_stateNext;
  logic [7:0] r_starveCnt;
  logic [1:0] r_rrPtr;
  logic [2:0] r_errLatched;

  logic       w_live;
  logic       w_sEl, w_arEl, w_rEl, w_pfEl, w_otherEl;
  logic       w_grantS, w_rrGo;
  logic       w_grantAr, w_grantR, w_grantPf;
  logic [1:0] w_winner;

  // Nothing is granted while reset is held or while in ERROR. The resetN
  // term keeps the outputs quiet during reset, not just after the first edge.
  assign w_live    = resetN & (r_state != S_ERROR);
  assign w_sEl     = w_live & s_r_valid;
  assign w_rEl     = w_live & q_pr_r_valid & m_r_ready;
  assign w_arEl    = w_live & (r_state == S_RUN) & m_ar_valid;
  assign w_pfEl    = w_live & (r_state == S_RUN) & pf_valid & ~q_almostFull;
  assign w_otherEl = w_arEl | w_rEl | w_pfEl;

  // Slave data wins unless it has already been granted STARVE_LIMIT times
  // in a row while someone else was waiting.
  assign w_grantS = w_sEl & ~((r_starveCnt == LP_LIMIT) & w_otherEl);
  assign w_rrGo   = w_otherEl & ~w_grantS;

  // Round-robin search order is AR(0) -> R(1) -> PF(2), starting at rrPtr.
  // The illegal pointer value 3 falls into the default and behaves as 0.
  always_comb begin
    w_winner = 2'd0;
    case (r_rrPtr)
      2'd1: begin
        if (w_rEl)       w_winner = 2'd1;
        else if (w_pfEl) w_winner = 2'd2;
        else             w_winner = 2'd0;
      end
      2'd2: begin
        if (w_pfEl)      w_winner = 2'd2;
        else if (w_arEl) w_winner = 2'd0;
        else             w_winner = 2'd1;
      end
      default: begin
        if (w_arEl)      w_winner = 2'd0;
        else if (w_rEl)  w_winner = 2'd1;
        else             w_winner = 2'd2;
      end
    endcase
  end

  assign w_grantAr = w_rrGo & (w_winner == 2'd0);
  assign w_grantR  = w_rrGo & (w_winner == 2'd1);
  assign w_grantPf = w_rrGo & (w_winner == 2'd2);

  // m_r_valid is only raised in the cycle the promise opcode goes out, so
  // the master never sees a beat that the queue did not also see retired.
  assign s_r_ready  = w_grantS;
  assign m_ar_ready = w_grantAr;
  assign m_r_valid  = w_grantR;
  assign pf_ready   = w_grantPf;

  // Opcode and address towards the queue; exactly one grant is ever active.
  always_comb begin
    q_reqOpcode = 3'd0;
    q_reqAddr   = '0;
    if (w_grantS) begin
      q_reqOpcode = 3'd3;
    end else if (w_grantAr) begin
      q_reqOpcode = 3'd2;
      q_reqAddr   = m_ar_addr;
    end else if (w_grantR) begin
      q_reqOpcode = 3'd4;
    end else if (w_grantPf) begin
      q_reqOpcode = 3'd1;
      q_reqAddr   = pf_addr;
    end
  end

  // Next state. A fresh queue error overrides every other transition, and it
  // also beats a simultaneous errClear while already in ERROR.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (crs_enable) w_stateNext = S_RUN;
      S_RUN:   if (!crs_enable) w_stateNext = S_DRAIN;
      S_DRAIN: begin
        if (crs_enable)            w_stateNext = S_RUN;
        else if (!q_hasOutstanding) w_stateNext = S_IDLE;
      end
      S_ERROR: if (crs_errClear && (q_errorCode == 3'd0)) w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
    if ((r_state != S_ERROR) && (q_errorCode != 3'd0)) w_stateNext = S_ERROR;
  end

  // State register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= S_IDLE;
    else         r_state <= w_stateNext;
  end

  // Starvation counter and round-robin pointer. The counter only grows while
  // slave data is being granted over a waiting requester; anything else
  // clears it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_starveCnt <= 8'd0;
      r_rrPtr     <= 2'd0;
    end else begin
      if (w_grantS && w_otherEl)
        r_starveCnt <= (r_starveCnt == LP_LIMIT) ? r_starveCnt : r_starveCnt + 8'd1;
      else
        r_starveCnt <= 8'd0;
      if (w_rrGo)
        r_rrPtr <= (w_winner == 2'd2) ? 2'd0 : w_winner + 2'd1;
    end
  end

  // Sticky error capture: only the first nonzero code after a clear is kept.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_errLatched <= 3'd0;
    end else if ((q_errorCode != 3'd0) && (r_errLatched == 3'd0)) begin
      r_errLatched <= q_errorCode;
    end else if ((r_state == S_ERROR) && crs_errClear && (q_errorCode == 3'd0)) begin
      r_errLatched <= 3'd0;
    end
  end

  assign state      = r_state;
  assign errLatched = r_errLatched;

endmodule
